// File: rtl/seq_divider_restoring.sv
// seq_divider_restoring: multi-cycle unsigned restoring divider, one quotient bit per clock; DIV_SELFCHECK_EN adds a q*d+r==dividend check_err output
module seq_divider_restoring #(
  parameter int VW = 4,
  parameter int DW = 2 * VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
`ifdef DIV_SELFCHECK_EN
  ,
  output logic          check_err
`endif
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(DW + 1);
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dq;
  logic [VW-1:0] dsr;
  logic [VW:0]   prem, sh, trial;
  logic          dbz, accept;
  assign accept = start && state != RUN;
  assign busy   = state == RUN;
  always_comb begin
    sh    = {prem[VW-1:0], dq[DW-1]};
    trial = sh - {1'b0, dsr};
  end
`ifdef DIV_SELFCHECK_EN
  localparam int PW = DW + VW;
  logic [DW-1:0] dvd_l;
  logic [PW-1:0] prod;
  logic          chk;
  always_comb begin
    prod = PW'(dq) * PW'(dsr) + PW'(prem[VW-1:0]);
    chk  = !dbz && prod != PW'(dvd_l);
  end
`endif
  // Results reach the outputs on the edge that raises done, so a start taken in DONE never disturbs them early
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      dsr         <= '0;
      prem        <= '0;
      dbz         <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SELFCHECK_EN
      dvd_l       <= '0;
      check_err   <= 1'b0;
`endif
    end else begin
      done <= state == DONE;
      if (state == DONE) begin
        quotient    <= dq;
        remainder   <= prem[VW-1:0];
        div_by_zero <= dbz;
`ifdef DIV_SELFCHECK_EN
        check_err   <= chk;
`endif
      end
      if (accept) begin
        dsr   <= divisor;
        cnt   <= CW'(DW);
        dbz   <= divisor == '0;
        dq    <= divisor == '0 ? '1 : dividend;
        prem  <= divisor == '0 ? {1'b0, dividend[VW-1:0]} : '0;
        state <= divisor == '0 ? DONE : RUN;
`ifdef DIV_SELFCHECK_EN
        dvd_l <= dividend;
`endif
      end else if (state == RUN) begin
        prem <= trial[VW] ? sh : trial;
        dq   <= {dq[DW-2:0], !trial[VW]};
        cnt  <= cnt - 1'b1;
        if (cnt == CW'(1)) state <= DONE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider_restoring.sv
// tb_seq_divider_restoring: randomized and directed scoreboard bench for seq_divider_restoring
module tb_seq_divider_restoring;
  logic       clk = 0, rst = 1, start = 0;
  logic [7:0] dividend = 0;
  logic [3:0] divisor = 0;
  logic       busy, done, dbz;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIV_SELFCHECK_EN
  logic       check_err;
`endif
  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         t;
    int         nb;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, total = 0, bad = 0, tmo_cnt = 0, tmo_seen = 0, bcnt = 0;

  seq_divider_restoring dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(dbz)
`ifdef DIV_SELFCHECK_EN
    , .check_err(check_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, want, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_q", 32'(quotient), 0);
      chk("rst_r", 32'(remainder), 0);
      chk("rst_z", 32'(dbz), 0);
      bcnt = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 32'(done), 0);
        else begin
          e = sb.pop_front();
          chk("quotient", 32'(quotient), 32'(e.q));
          chk("remainder", 32'(remainder), 32'(e.r));
          chk("div_by_zero", 32'(dbz), 32'(e.z));
          chk("latency", 32'(cyc), 32'(e.t));
          chk("busy_cycles", 32'(bcnt), 32'(e.nb));
          if (!e.z) begin
            chk("q*d+r", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
            chk("r<d", 32'(remainder < e.b), 1);
          end
`ifdef DIV_SELFCHECK_EN
          chk("check_err", 32'(check_err), 0);
`endif
        end
        bcnt = 0;
      end
      if (busy) bcnt++;
    end
    if (tmo_cnt != tmo_seen) begin
      chk("timeout", 32'(tmo_cnt), 32'(tmo_seen));
      tmo_seen = tmo_cnt;
    end
  end

  // Called at a falling edge; pushes the reference result for the accepted start
  task automatic issue(input logic [7:0] a, input logic [3:0] b, input bit rec = 1);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1;
    @(negedge clk);
    start    = 0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    if (rec) begin
      e.a  = a;
      e.b  = b;
      e.z  = b == 0;
      e.q  = b != 0 ? a / b : 8'hFF;
      e.r  = b != 0 ? 4'(a % b) : a[3:0];
      e.t  = cyc + (b != 0 ? 9 : 1);
      e.nb = b != 0 ? 8 : 0;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) tmo_cnt++;
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    issue(200, 7); wait_idle();
    issue(255, 1); wait_idle();
    issue(0, 15); wait_idle();
    issue(225, 15); wait_idle();
    issue(8'h5A, 0); wait_idle();
    issue(100, 3);
    s = cyc;
    repeat (3) @(negedge clk);
    dividend = 50; divisor = 5; start = 1;
    @(negedge clk);
    start = 0; dividend = 8'($urandom); divisor = 4'($urandom);
    while (cyc < s + 8) @(negedge clk);
    issue(50, 5); wait_idle();
    issue(200, 9, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    issue(17, 4); wait_idle();
    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++) begin
        issue(8'(a), 4'(b));
        wait_idle();
      end
    for (int i = 0; i < 300; i++) begin
      issue(8'($urandom), 4'($urandom_range(0, 15)));
      wait_idle();
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_divider_restoring.md
Name: seq_divider_restoring

Overview:
- Multi-cycle unsigned restoring divider. Inverse operation of the team's 4x4 array/tree multiplier: takes the 2*VW-bit product-width dividend and a VW-bit divisor, and returns quotient and remainder.
- Shares operand widths with the multiplier.
- Used in arithmetic-tree verification loops: multiply, then divide back.
- Processes one quotient bit per clock through a start/busy/done handshake.

Parameters:
- VW, 4: divisor and remainder width.
- DW, 2*VW (8): dividend and quotient width. Also the number of iteration cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE or DONE.
- dividend  input  DW  unsigned dividend. Captured on the accepted start edge.
- divisor  input  VW  unsigned divisor. Captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  DW  result. Held until the next accepted start.
- remainder  output  VW  result. Held until the next accepted start.
- div_by_zero  output  1  valid with done. Held with the results.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; the iteration counter clears.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Reset mid-RUN aborts the operation and produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder (VW+1 bits) and set the counter to DW.
  - If divisor==0: go to DONE with quotient={DW{1}}, remainder=dividend[VW-1:0], div_by_zero=1.
  - Otherwise go to RUN with div_by_zero=0.
- RUN, each edge:
  - Shift {partial remainder, dividend register} left by 1.
  - trial = partial remainder - {0, divisor}, at VW+1 bits.
  - If trial is non-negative: partial remainder = trial and the shifted-in quotient bit is 1. Otherwise restore, with quotient bit 0.
  - Decrement the counter. When the counter reaches 0 (after exactly DW RUN edges), go to DONE and drive quotient and remainder[VW-1:0] from the working registers.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - If start=1 in DONE, it is accepted exactly as in IDLE, so back-to-back operation is supported.
- Latency, with the start edge counted as edge 0:
  - Nonzero divisor: done is high in the cycle after edge DW+1 (9 edges total for DW=8).
  - Zero divisor: done is high after edge 1.
- busy is 1 exactly during RUN. start asserted while busy=1 is ignored and has no side effects.
- Operands may change after the accepted start edge without affecting the result.
- quotient, remainder and div_by_zero are stable from done until the next accepted start. They are not cleared in IDLE.
- Invariants:
  - Nonzero divisor: quotient*divisor + remainder == dividend, and remainder < divisor.
  - Quotient always fits in DW bits (VW-bit divisor ≥ 1).
- All arithmetic is unsigned. No signed mode.

Optional Feature:
- Macro: DIV_SELFCHECK_EN.
- Defined:
  - Adds output port check_err (1 bit, reset 0).
  - In DONE with div_by_zero=0, the block computes quotient*divisor + remainder at DW+VW bits. It uses a combinational multiplier mirroring the team's partial-product tree, or the behavioural * operator.
  - The sum is compared to the latched dividend. check_err is set for the done cycle on mismatch and held with the results.
  - check_err is 0 when div_by_zero=1.
- Undefined: no check_err port, no multiplier logic. All other timing is identical.

Test Plan:
- rst; dividend=200, divisor=7, start pulse -> busy high for 8 cycles, done after edge 9, quotient=28, remainder=4, div_by_zero=0, check_err=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=0, divisor=15 -> quotient=0, remainder=0. Then dividend=225, divisor=15 -> quotient=15, remainder=0.
- dividend=0x5A, divisor=0 -> done after edge 1, div_by_zero=1, quotient=0xFF, remainder=0xA, busy never high.
- Start 100/3; during RUN, pulse start with 50/5 and change operand inputs -> ignored; result is quotient=33, remainder=1. Then assert start in the DONE cycle with 50/5 -> accepted, next result quotient=10, remainder=0.
- Start 200/9, assert rst at the 4th RUN edge -> all outputs 0, no done pulse. A subsequent 17/4 -> quotient=4, remainder=1.
- Exhaustive sweep of all 256×15 nonzero-divisor pairs -> every result satisfies q*d+r==dividend and r<d. With DIV_SELFCHECK_EN, check_err stays 0 throughout.
